// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: plays a program from a local RAM into the cpu's load/start/wait handshake
// and records each retired instruction's output and status flags. Rev 1.0
`default_nettype none

module cpu_instr_sequencer #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          run,
  input  logic [AW:0]   num_instr,
  input  logic          abort,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic          cpu_w,
  input  logic [15:0]   cpu_out,
  input  logic          cpu_N,
  input  logic          cpu_V,
  input  logic          cpu_Z,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   result,
  output logic [2:0]    flags,
  output logic [AW:0]   retired
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_DONE, S_ERROR
  } state_t;

  state_t          state, state_nx;
  logic [15:0]     mem [0:(1<<AW)-1];
  logic [15:0]     rd_data;
  logic [15:0]     in_hold;
  logic [AW-1:0]   ptr;
  logic [AW:0]     remaining;
  logic [WDW-1:0]  wdog;
  logic            wd_expired;
  logic            idle_like;
  logic            start_run;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign start_run  = run && ((state == S_IDLE) || (state == S_DONE));
  assign wd_expired = ((state == S_START) || (state == S_WAIT)) && (wdog == WD_LAST);

  assign busy  = !idle_like;
  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);
  // The word is presented combinationally while loading, then held for the cpu.
  assign cpu_in = (state == S_LOAD) ? rd_data : in_hold;

  always_ff @(posedge clk) begin
    if (prog_we && idle_like)
      mem[prog_addr] <= prog_data;
    rd_data <= mem[ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cpu_load = 1'b0;
    cpu_s    = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (run) state_nx = (num_instr == '0) ? S_DONE : S_FETCH;
      S_FETCH:        state_nx = S_LOAD;
      S_LOAD: begin
        if (cpu_w) begin
          cpu_load = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: begin
        cpu_s = 1'b1;
        if (!cpu_w) state_nx = S_WAIT;
      end
      S_WAIT:         if (cpu_w) state_nx = S_CAPTURE;
      S_CAPTURE:      state_nx = (remaining == (AW+1)'(1)) ? S_DONE : S_FETCH;
      default:        state_nx = state;
    endcase
    if (wd_expired) begin
      state_nx = S_ERROR;
      cpu_s    = 1'b0;
    end
    if (abort) begin
      state_nx = S_IDLE;
      cpu_load = 1'b0;
      cpu_s    = 1'b0;
    end
    if (reset) begin
      cpu_load = 1'b0;
      cpu_s    = 1'b0;
    end
  end

  // Watchdog runs only across the start/wait window and restarts on every START entry.
  always_ff @(posedge clk) begin
    if (reset || ((state != S_START) && (state != S_WAIT))) wdog <= '0;
    else                                                  wdog <= wdog + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      flags     <= '0;
      retired   <= '0;
      ptr       <= '0;
      remaining <= '0;
      in_hold   <= '0;
    end else if (!abort) begin
      if (start_run) begin
        ptr       <= '0;
        retired   <= '0;
        remaining <= num_instr;
      end
      if ((state == S_LOAD) && cpu_w)
        in_hold <= rd_data;
      if (state == S_CAPTURE) begin
        result    <= cpu_out;
        flags     <= {cpu_Z, cpu_N, cpu_V};
        retired   <= retired + 1'b1;
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_instr_sequencer.sv
// Scoreboard bench for cpu_instr_sequencer with a behavioural cpu handshake model.
`default_nettype none

module tb_cpu_instr_sequencer;
  localparam int AW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset, prog_we, run, abort;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [AW:0]   num_instr;
  logic [15:0]   cpu_in, cpu_out, result;
  logic          cpu_load, cpu_s, cpu_w, cpu_N, cpu_V, cpu_Z;
  logic          busy, done, error;
  logic [2:0]    flags;
  logic [AW:0]   retired;

  cpu_instr_sequencer #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .num_instr(num_instr), .abort(abort),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w),
    .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
    .busy(busy), .done(done), .error(error), .result(result),
    .flags(flags), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  fl;
    logic [AW:0] ret;
    logic        is_err;
  } end_t;

  logic [15:0] load_q[$];
  end_t        end_q[$];
  logic [15:0] prog [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Mock cpu results, keyed by instruction word: {flags(Z,N,V), out}.
  // The test program's words give the register values that program is meant to produce.
  function automatic logic [18:0] exec(input logic [15:0] w);
    case (w)
      16'hD105: exec = {3'b000, 16'h0005};
      16'hD203: exec = {3'b000, 16'h0003};
      16'hA061: exec = {3'b000, 16'h0008};
      16'h6060: exec = {3'b000, 16'h0008};
      default:  exec = {w[2:0], w ^ 16'h5A5A};
    endcase
  endfunction

  logic [15:0] m_in;
  logic        m_busy;
  int          m_cnt;
  logic        hang;

  always @(posedge clk) begin
    if (reset) begin
      cpu_w <= 1'b1; m_busy <= 1'b0; m_cnt <= 0; m_in <= '0;
      cpu_out <= '0; {cpu_Z, cpu_N, cpu_V} <= '0;
    end else begin
      if (cpu_load) m_in <= cpu_in;
      if (cpu_s && cpu_w && !m_busy) begin
        cpu_w <= 1'b0; m_busy <= 1'b1; m_cnt <= 2;
      end else if (m_busy && !hang) begin
        if (m_cnt != 0) m_cnt <= m_cnt - 1;
        else begin
          {cpu_Z, cpu_N, cpu_V, cpu_out} <= exec(m_in);
          cpu_w <= 1'b1; m_busy <= 1'b0;
        end
      end
    end
  end

  logic        done_p = 1'b0, err_p = 1'b0;
  logic [15:0] mon_word;
  end_t        mon_end;

  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_load) begin
        if (load_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_load actual=%0h required=no_load", cpu_in);
        end else begin
          mon_word = load_q.pop_front();
          chk("load_word", {16'h0, cpu_in}, {16'h0, mon_word});
          chk("load_s_excl", {31'h0, cpu_s}, 32'h0);
        end
      end
      if ((done && !done_p) || (error && !err_p)) begin
        if (end_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_end actual=done%0b_err%0b required=none", done, error);
        end else begin
          mon_end = end_q.pop_front();
          chk("end_result", {16'h0, result}, {16'h0, mon_end.res});
          chk("end_flags", {29'h0, flags}, {29'h0, mon_end.fl});
          chk("end_retired", 32'(retired), 32'(mon_end.ret));
          chk("end_kind_error", {31'h0, error}, {31'h0, mon_end.is_err});
        end
      end
    end
    done_p = done;
    err_p  = error;
  end

  task automatic push_loads(input int n);
    for (int i = 0; i < n; i++) load_q.push_back(prog[i % 8]);
  endtask

  task automatic push_end(input logic [15:0] r, input logic [2:0] f, input int n, input logic e);
    end_q.push_back('{res: r, fl: f, ret: (AW+1)'(n), is_err: e});
  endtask

  task automatic start(input int n);
    run = 1'b1;
    num_instr = (AW+1)'(n);
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    for (int i = 0; i < 400 && !(done || error); i++) @(negedge clk);
    if (!(done || error)) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=busy required=done_or_error", nm);
    end
    @(negedge clk);
  endtask

  task automatic wait_cpu_s(input string nm);
    for (int i = 0; i < 100 && !cpu_s; i++) @(negedge clk);
    if (!cpu_s) begin
      checks++; failures++;
      $display("FAIL %s_no_start actual=0 required=cpu_s", nm);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_cpu_in"}, {16'h0, cpu_in}, 32'h0);
    chk({nm, "_cpu_load"}, {31'h0, cpu_load}, 32'h0);
    chk({nm, "_cpu_s"}, {31'h0, cpu_s}, 32'h0);
    chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
    chk({nm, "_done"}, {31'h0, done}, 32'h0);
    chk({nm, "_error"}, {31'h0, error}, 32'h0);
    chk({nm, "_result"}, {16'h0, result}, 32'h0);
    chk({nm, "_flags"}, {29'h0, flags}, 32'h0);
    chk({nm, "_retired"}, 32'(retired), 32'h0);
  endtask

  initial begin
    int k;
    reset = 1'b1; prog_we = 1'b0; run = 1'b0; abort = 1'b0; hang = 1'b0;
    prog_addr = '0; prog_data = '0; num_instr = '0;
    prog[0] = 16'hD105; prog[1] = 16'hD203; prog[2] = 16'hA061; prog[3] = 16'h6060;
    prog[4] = 16'h1111; prog[5] = 16'h2222; prog[6] = 16'h3333; prog[7] = 16'h7774;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = prog[i];
      @(negedge clk);
    end
    prog_we = 1'b0;

    // Four-instruction program: 5 + 3 = 8
    push_loads(4); push_end(16'h0008, 3'b000, 4, 1'b0);
    start(4);
    wait_end("prog4");
    chk("prog4_busy", {31'h0, busy}, 32'h0);

    // Zero-length run completes in one cycle without touching the cpu
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_to_idle_done", {31'h0, done}, 32'h0);
    push_end(16'h0008, 3'b000, 0, 1'b0);
    start(0);
    chk("zero_run_done", {31'h0, done}, 32'h1);
    chk("zero_run_retired", 32'(retired), 32'h0);

    // Abort while waiting on the second instruction
    push_loads(2);
    start(4);
    for (int i = 0; i < 100 && !(retired == 1 && busy && !cpu_s && !cpu_w); i++) @(negedge clk);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_cpu_s", {31'h0, cpu_s}, 32'h0);
    chk("abort_retired", 32'(retired), 32'h1);
    chk("abort_result", {16'h0, result}, 32'h0005);
    repeat (8) @(negedge clk);
    push_loads(4); push_end(16'h0008, 3'b000, 4, 1'b0);
    start(4);
    wait_end("rerun");

    // Host write while busy must not reach the RAM
    push_loads(2); push_end(16'h0003, 3'b000, 2, 1'b0);
    start(2);
    @(negedge clk);
    chk("we_busy", {31'h0, busy}, 32'h1);
    prog_we = 1'b1; prog_addr = AW'(1); prog_data = 16'hFFFF;
    @(negedge clk);
    prog_we = 1'b0;
    wait_end("we_run");
    push_loads(2); push_end(16'h0003, 3'b000, 2, 1'b0);
    start(2);
    wait_end("readback");
    chk("readback_cpu_in", {16'h0, cpu_in}, 32'hD203);

    // Watchdog: cpu never returns w
    hang = 1'b1;
    push_loads(1); push_end(16'h0003, 3'b000, 0, 1'b1);
    start(1);
    wait_cpu_s("wd");
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (error) begin k = i; break; end
    end
    chk("wd_latency", 32'(k), 32'd16);
    chk("wd_cpu_s", {31'h0, cpu_s}, 32'h0);
    chk("wd_busy", {31'h0, busy}, 32'h0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    hang = 1'b0;
    repeat (6) @(negedge clk);
    chk("wd_cleared", {31'h0, error}, 32'h0);

    // Reset in START, then a normal run
    push_loads(1);
    start(4);
    wait_cpu_s("rst");
    reset = 1'b1; @(negedge clk);
    chk_all_zero("rst_start");
    reset = 1'b0;
    @(negedge clk);
    push_loads(4); push_end(16'h0008, 3'b000, 4, 1'b0);
    start(4);
    wait_end("after_rst");

    // Full-depth run: pointer covers every address; last word sets Z only
    push_loads(8); push_end(16'h2D2E, 3'b100, 8, 1'b0);
    start(8);
    wait_end("full");

    repeat (2) @(negedge clk);
    chk("loads_drained", 32'(load_q.size()), 32'h0);
    chk("ends_drained", 32'(end_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
